// File: rtl/post_code_pkg.sv
// Shared constants for the POST-code snoop/readback block: default I/O ports,
// the value returned by a data read on an empty history, and status bit layout.
package post_code_pkg;

   localparam logic [19:0] POST_ADDR_DEFAULT   = 20'h00080;
   localparam logic [19:0] STATUS_ADDR_DEFAULT = 20'h003DE;
   localparam logic [19:0] DATA_ADDR_DEFAULT   = 20'h003DF;
   localparam int          DEPTH_LOG2_DEFAULT  = 4;

   localparam logic [7:0]  EMPTY_READ_VALUE    = 8'hFF;

   // Status byte: {ovf, full, empty, count[4:0]}
   localparam int ST_OVF_BIT   = 7;
   localparam int ST_FULL_BIT  = 6;
   localparam int ST_EMPTY_BIT = 5;
   localparam int ST_COUNT_W   = 5;

endpackage

// File: rtl/post_code_readback_if.sv
// ISA front-end signals seen by the POST-code readback block.
// The host side (master) drives address/strobes/data; the card (slave) returns read data and its enable.
interface post_code_readback_if;

   logic        isa_addr_en;
   logic        isa_io_write;
   logic        isa_io_read;
   logic [19:0] isa_addr;
   logic [7:0]  isa_data;
   logic [7:0]  isa_data_out;
   logic        isa_data_oe;

   modport master (
      output isa_addr_en, isa_io_write, isa_io_read, isa_addr, isa_data,
      input  isa_data_out, isa_data_oe
   );

   modport slave (
      input  isa_addr_en, isa_io_write, isa_io_read, isa_addr, isa_data,
      output isa_data_out, isa_data_oe
   );

endinterface

// File: rtl/post_code_fifo.sv
// History ring buffer. A push into a full buffer overwrites the oldest entry and
// reports ovf_evt; a simultaneous push and pop never overflows.
module post_code_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [7:0]            din,
   output logic [7:0]            dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  ovf_evt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_pop;

   assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign ovf_evt = push & ~pop & full;

   // Contents are intentionally left unreset; emptiness is tracked by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop || ovf_evt) rd_ptr <= rd_ptr + 1'b1;
         // Push+pop on empty keeps the byte and loses the pop, so count goes to 1.
         if (push && !do_pop && !full) count <= count + 1'b1;
         else if (do_pop && !push)     count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/post_code_readback.sv
// POST-code snoop with host readback: decodes ISA I/O cycles, acts on strobe trailing
// edges, keeps a sticky overflow flag and muxes status/history onto the read data path.
module post_code_readback
   import post_code_pkg::*;
#(
   parameter logic [19:0] POST_ADDR   = POST_ADDR_DEFAULT,
   parameter logic [19:0] STATUS_ADDR = STATUS_ADDR_DEFAULT,
   parameter logic [19:0] DATA_ADDR   = DATA_ADDR_DEFAULT,
   parameter int          DEPTH_LOG2  = DEPTH_LOG2_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   post_code_readback_if.slave  bus,
   output logic [DEPTH_LOG2:0]  fifo_count
);

   logic       wr_cs, rd_st, rd_dt;
   logic       wr_q, st_q, dt_q;
   logic [7:0] data_q;
   logic       push_evt, pop_evt, st_evt;
   logic       ovf;
   logic [7:0] head;
   logic       full, empty, ovf_evt;
   logic [7:0] status;

   assign wr_cs = (bus.isa_addr == POST_ADDR)   & ~bus.isa_addr_en & ~bus.isa_io_write;
   assign rd_st = (bus.isa_addr == STATUS_ADDR) & ~bus.isa_addr_en & ~bus.isa_io_read;
   assign rd_dt = (bus.isa_addr == DATA_ADDR)   & ~bus.isa_addr_en & ~bus.isa_io_read;

   // Strobes are slow relative to clk; a single register stage is the edge detector.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= 1'b0;
         st_q   <= 1'b0;
         dt_q   <= 1'b0;
         data_q <= 8'h00;
      end else begin
         wr_q   <= wr_cs;
         st_q   <= rd_st;
         dt_q   <= rd_dt;
         data_q <= bus.isa_data;
      end
   end

   assign push_evt = wr_q & ~wr_cs;
   assign pop_evt  = dt_q & ~rd_dt;
   assign st_evt   = st_q & ~rd_st;

   post_code_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_evt),
      .pop     (pop_evt),
      .din     (data_q),
      .dout    (head),
      .count   (fifo_count),
      .full    (full),
      .empty   (empty),
      .ovf_evt (ovf_evt)
   );

   // A fresh overflow outranks the clear from a status read in the same clk.
   always_ff @(posedge clk) begin
      if (reset)        ovf <= 1'b0;
      else if (ovf_evt) ovf <= 1'b1;
      else if (st_evt)  ovf <= 1'b0;
   end

   always_comb begin
      status                   = 8'h00;
      status[ST_OVF_BIT]       = ovf;
      status[ST_FULL_BIT]      = full;
      status[ST_EMPTY_BIT]     = empty;
      status[ST_COUNT_W-1:0]   = ST_COUNT_W'(fifo_count);
   end

   always_comb begin
      bus.isa_data_out = 8'h00;
      if (rd_st)      bus.isa_data_out = status;
      else if (rd_dt) bus.isa_data_out = empty ? EMPTY_READ_VALUE : head;
   end

   assign bus.isa_data_oe = (rd_st | rd_dt) & ~reset;

endmodule

// File: tb/tb_post_code_readback.sv
// Bench for post_code_readback: directed scenarios plus random bus traffic, checked every
// cycle against a queue model of the POST-code history; the ring buffer is also driven directly.
module tb_post_code_readback;
   import post_code_pkg::*;

   localparam logic [19:0] A_POST = 20'h00080;
   localparam logic [19:0] A_ST   = 20'h003DE;
   localparam logic [19:0] A_DT   = 20'h003DF;

   logic       clk;
   logic       reset;
   logic [4:0] fifo_count;

   post_code_readback_if bus_if ();

   post_code_readback u_dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus_if.slave),
      .fifo_count (fifo_count)
   );

   logic       f_push, f_pop, f_full, f_empty, f_ovf, f_ovf_seen;
   logic [7:0] f_din, f_dout;
   logic [4:0] f_count;

   post_code_fifo #(.DEPTH_LOG2(4)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (f_push),
      .pop     (f_pop),
      .din     (f_din),
      .dout    (f_dout),
      .count   (f_count),
      .full    (f_full),
      .empty   (f_empty),
      .ovf_evt (f_ovf)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / model ----------------
   logic [7:0] exp_q[$];
   logic       m_ovf;
   int         n_vec;
   int         n_err;
   bit         chk_en;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_status();
      logic [7:0] s;
      s = {m_ovf, exp_q.size() == 16, exp_q.size() == 0, 5'(exp_q.size())};
      return s;
   endfunction

   task automatic model_push(input logic [7:0] d);
      if (exp_q.size() == 16) begin
         void'(exp_q.pop_front());
         m_ovf = 1'b1;
      end
      exp_q.push_back(d);
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_ovf = 1'b0;
   endtask

   // Per-cycle compare of every visible output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic       rs, rd, e_oe;
         logic [7:0] e_do;
         rs   = (bus_if.isa_addr == A_ST) && !bus_if.isa_addr_en && !bus_if.isa_io_read;
         rd   = (bus_if.isa_addr == A_DT) && !bus_if.isa_addr_en && !bus_if.isa_io_read;
         e_oe = (rs || rd) && !reset;
         e_do = 8'h00;
         if (rs)      e_do = model_status();
         else if (rd) e_do = (exp_q.size() == 0) ? 8'hFF : exp_q[0];
         chk("count", {3'b0, fifo_count}, 8'(exp_q.size()));
         chk("oe", {7'b0, bus_if.isa_data_oe}, {7'b0, e_oe});
         chk("data_out", bus_if.isa_data_out, e_do);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_write(input logic [19:0] a, input logic [7:0] d, input int len, input logic aen);
      @(posedge clk); #1;
      bus_if.isa_addr = a; bus_if.isa_data = d; bus_if.isa_addr_en = aen;
      bus_if.isa_io_write = 1'b0;
      repeat (len) @(posedge clk);
      #1;
      bus_if.isa_io_write = 1'b1; bus_if.isa_addr_en = 1'b0;
      bus_if.isa_data = 8'($urandom);
      @(posedge clk);
      if (a == A_POST && !aen) model_push(d);
      #1;
   endtask

   task automatic bus_read(input logic [19:0] a, input int len, input logic aen, output logic [7:0] got);
      @(posedge clk); #1;
      bus_if.isa_addr = a; bus_if.isa_addr_en = aen;
      bus_if.isa_io_read = 1'b0;
      repeat (len - 1) @(posedge clk);
      @(negedge clk);
      got = bus_if.isa_data_out;
      @(posedge clk); #1;
      bus_if.isa_io_read = 1'b1; bus_if.isa_addr_en = 1'b0;
      @(posedge clk);
      if (!aen && a == A_ST) m_ovf = 1'b0;
      if (!aen && a == A_DT && exp_q.size() != 0) void'(exp_q.pop_front());
      #1;
   endtask

   task automatic f_op(input logic p, input logic q, input logic [7:0] d);
      @(posedge clk); #1;
      f_push = p; f_pop = q; f_din = d;
      @(negedge clk);
      f_ovf_seen = f_ovf;
      @(posedge clk); #1;
      f_push = 1'b0; f_pop = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  got;
      logic [19:0] other_addr [4];
      other_addr[0] = A_ST; other_addr[1] = A_DT;
      other_addr[2] = 20'h00081; other_addr[3] = 20'h00180;
      n_vec = 0; n_err = 0; chk_en = 1'b0; m_ovf = 1'b0;
      f_push = 1'b0; f_pop = 1'b0; f_din = 8'h00; f_ovf_seen = 1'b0;
      bus_if.isa_addr_en = 1'b0; bus_if.isa_io_write = 1'b1; bus_if.isa_io_read = 1'b1;
      bus_if.isa_addr = 20'h0; bus_if.isa_data = 8'h00;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_count", {3'b0, fifo_count}, 8'h00);
      chk("reset_oe", {7'b0, bus_if.isa_data_oe}, 8'h00);
      chk("reset_data_out", bus_if.isa_data_out, 8'h00);

      // Basic history and readback order
      bus_write(A_POST, 8'h12, 8, 1'b0);
      bus_write(A_POST, 8'h34, 8, 1'b0);
      bus_write(A_POST, 8'h56, 8, 1'b0);
      bus_read(A_ST, 4, 1'b0, got); chk("t1_status", got, 8'h03);
      bus_read(A_DT, 4, 1'b0, got); chk("t1_rd0", got, 8'h12);
      bus_read(A_DT, 4, 1'b0, got); chk("t1_rd1", got, 8'h34);
      bus_read(A_DT, 4, 1'b0, got); chk("t1_rd2", got, 8'h56);
      bus_read(A_DT, 4, 1'b0, got); chk("t1_rd_empty", got, 8'hFF);
      bus_read(A_ST, 4, 1'b0, got); chk("t1_status_empty", got, 8'h20);

      // Overflow drops the oldest entries; status read clears ovf
      for (int i = 0; i < 18; i++) bus_write(A_POST, 8'(i), 2, 1'b0);
      bus_read(A_ST, 3, 1'b0, got); chk("t2_status_ovf", got, 8'hD0);
      for (int i = 0; i < 16; i++) begin
         bus_read(A_DT, 2, 1'b0, got);
         chk("t2_rd", got, 8'(i + 2));
      end
      bus_read(A_ST, 3, 1'b0, got); chk("t2_status_clr", got, 8'h20);

      // Long strobe gives exactly one push
      bus_write(A_POST, 8'h77, 200, 1'b0);
      @(negedge clk); chk("t3_count", {3'b0, fifo_count}, 8'h01);

      // DMA cycles are ignored
      bus_write(A_POST, 8'h99, 4, 1'b1);
      bus_read(A_DT, 4, 1'b1, got);
      @(negedge clk); chk("t4_count", {3'b0, fifo_count}, 8'h01);
      bus_read(A_DT, 3, 1'b0, got); chk("t4_head", got, 8'h77);

      // Reset during an active data read
      for (int i = 0; i < 4; i++) bus_write(A_POST, 8'hC0 + 8'(i), 2, 1'b0);
      @(posedge clk); #1;
      bus_if.isa_addr = A_DT; bus_if.isa_io_read = 1'b0;
      repeat (3) @(posedge clk);
      #1; reset = 1'b1;
      @(posedge clk);
      model_clear();
      @(negedge clk);
      chk("t6_oe_in_reset", {7'b0, bus_if.isa_data_oe}, 8'h00);
      chk("t6_count_in_reset", {3'b0, fifo_count}, 8'h00);
      @(posedge clk); #1; reset = 1'b0;
      repeat (3) @(posedge clk);
      #1; bus_if.isa_io_read = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t6_count_after", {3'b0, fifo_count}, 8'h00);

      // Simultaneous push and pop on the ring buffer itself
      for (int i = 0; i < 5; i++) f_op(1'b1, 1'b0, 8'h10 + 8'(i));
      f_op(1'b1, 1'b1, 8'h15);
      @(negedge clk);
      chk("t5_mid_count", {3'b0, f_count}, 8'h05);
      chk("t5_mid_head", f_dout, 8'h11);
      for (int i = 0; i < 11; i++) f_op(1'b1, 1'b0, 8'h16 + 8'(i));
      @(negedge clk);
      chk("t5_full", {7'b0, f_full}, 8'h01);
      f_op(1'b1, 1'b1, 8'h21);
      chk("t5_full_ovf", {7'b0, f_ovf_seen}, 8'h00);
      @(negedge clk);
      chk("t5_full_count", {3'b0, f_count}, 8'h10);
      chk("t5_full_head", f_dout, 8'h12);
      f_op(1'b1, 1'b0, 8'h22);
      chk("t5_push_full_ovf", {7'b0, f_ovf_seen}, 8'h01);
      @(negedge clk);
      chk("t5_push_full_head", f_dout, 8'h13);
      repeat (16) f_op(1'b0, 1'b1, 8'h00);
      @(negedge clk);
      chk("t5_empty", {7'b0, f_empty}, 8'h01);
      f_op(1'b1, 1'b1, 8'hA5);
      @(negedge clk);
      chk("t5_empty_count", {3'b0, f_count}, 8'h01);
      chk("t5_empty_head", f_dout, 8'hA5);

      // Random bus traffic
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 6))
            0, 1, 2: bus_write(A_POST, 8'($urandom), $urandom_range(1, 6), 1'b0);
            3:       bus_read(A_DT, $urandom_range(1, 5), 1'b0, got);
            4:       bus_read(A_ST, $urandom_range(1, 5), 1'b0, got);
            5:       bus_write(other_addr[$urandom_range(0, 3)], 8'($urandom), $urandom_range(1, 4), 1'b0);
            default: begin
               if ($urandom_range(0, 1) == 1) bus_write(A_POST, 8'($urandom), 3, 1'b1);
               else                           bus_read(A_DT, 3, 1'b1, got);
            end
         endcase
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
